// File: rtl/input_pkg.sv
// Shared definitions for the push-button debounce bank: state encoding and
// default timing constants for the 24.4 kHz user-input clock domain.
package input_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] QUAL     = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] REL_QUAL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = IDLE,
        S_QUAL     = QUAL,
        S_HELD     = HELD,
        S_REL_QUAL = REL_QUAL
    } state_e;

    // ~0.25 s qualification, ~0.5 s to first repeat, ~0.1 s repeat period
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 6100;
    localparam int unsigned DEF_REPEAT_DELAY    = 12200;
    localparam int unsigned DEF_REPEAT_PERIOD   = 2440;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_debounce_ch.sv
// One button channel: two-flop synchroniser, press/release qualification FSM
// and optional auto-repeat, all outputs registered.
module input_debounce_ch
    import input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic Btn,
    output logic Btn_pulse,
    output logic Btn_release,
    output logic Btn_level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT = RPT_W'(REPEAT_PERIOD - 1);

    state_e           r_state;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [RPT_W-1:0] r_rpt;
    logic             r_pulse;
    logic             r_release;
    logic             r_level;
    logic             w_sync;

    assign w_sync = r_sync[1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_sync    <= '0;
            r_cnt     <= '0;
            r_rpt     <= '0;
            r_pulse   <= 1'b0;
            r_release <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], Btn};
            r_pulse   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_sync) begin
                        r_state <= S_QUAL;
                    end
                end
                S_QUAL: begin
                    if (!w_sync) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_HELD;
                        r_pulse <= 1'b1;
                        r_level <= 1'b1;
                        r_rpt   <= RPT_FIRST;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    // rpt is left untouched on the way out so a bounce resumes the same schedule
                    if (!w_sync) begin
                        r_state <= S_REL_QUAL;
                        r_cnt   <= '0;
                    end else if (REPEAT_EN && (r_rpt == '0)) begin
                        r_pulse <= 1'b1;
                        r_rpt   <= RPT_NEXT;
                    end else if (r_rpt != '0) begin
                        r_rpt <= r_rpt - RPT_W'(1);
                    end
                end
                S_REL_QUAL: begin
                    if (w_sync) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= S_IDLE;
                        r_release <= 1'b1;
                        r_level   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Btn_pulse   = r_pulse;
    assign Btn_release = r_release;
    assign Btn_level   = r_level;

endmodule

// File: rtl/input_debounce_bank.sv
// Bank of independent debounced push-button channels with per-channel
// auto-repeat enable; feeds the board-cursor and menu logic.
module input_debounce_bank
    import input_pkg::*;
#(
    parameter int unsigned    N_CH            = 4,
    parameter int unsigned    DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned    REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned    REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [N_CH-1:0] REPEAT_EN      = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N_CH-1:0] Btn,
    output logic [N_CH-1:0] Btn_pulse,
    output logic [N_CH-1:0] Btn_release,
    output logic [N_CH-1:0] Btn_level
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_EN[i])
        ) u_ch (
            .CLK         (CLK),
            .RESET       (RESET),
            .Btn         (Btn[i]),
            .Btn_pulse   (Btn_pulse[i]),
            .Btn_release (Btn_release[i]),
            .Btn_level   (Btn_level[i])
        );
    end

endmodule

// File: tb/tb_input_debounce_bank.sv
// Bench for input_debounce_bank: directed timing tables, hand-written corner
// sequences and a randomized run against a run-length reference model.
module tb_input_debounce_bank;

    localparam int N_CH = 2;
    localparam int DC   = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;
    localparam logic [N_CH-1:0] REN = 2'b01;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [N_CH-1:0] Btn;
    logic [N_CH-1:0] Btn_pulse;
    logic [N_CH-1:0] Btn_release;
    logic [N_CH-1:0] Btn_level;

    int n_tests = 0;
    int n_fail  = 0;

    input_debounce_bank #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_EN       (REN)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Btn         (Btn),
        .Btn_pulse   (Btn_pulse),
        .Btn_release (Btn_release),
        .Btn_level   (Btn_level)
    );

    always #5 CLK = ~CLK;

    // Reference model: a channel flips its level once the synchronised input
    // has disagreed with it for DC+1 consecutive edges; repeats fire after
    // RD, RD+RP, ... steady-held edges counted from the press.
    logic [N_CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pulse = '0, m_rel = '0;
    int m_run [N_CH];
    int m_ticks [N_CH];

    task automatic model_update(input logic [N_CH-1:0] b, input logic r);
        logic s;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_rel = '0;
            for (int c = 0; c < N_CH; c++) begin
                m_run[c] = 0;
                m_ticks[c] = 0;
            end
        end else begin
            m_pulse = '0;
            m_rel   = '0;
            for (int c = 0; c < N_CH; c++) begin
                s = m_s2[c];
                if (s != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DC + 1) begin
                        m_lvl[c] = s;
                        m_run[c] = 0;
                        if (s) begin
                            m_pulse[c] = 1'b1;
                            m_ticks[c] = 0;
                        end else begin
                            m_rel[c] = 1'b1;
                        end
                    end
                end else begin
                    if (m_lvl[c] && m_run[c] == 0) begin
                        m_ticks[c]++;
                        if (REN[c] && m_ticks[c] >= RD && ((m_ticks[c] - RD) % RP) == 0)
                            m_pulse[c] = 1'b1;
                    end
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic step(input logic [N_CH-1:0] b, input logic r);
        Btn   = b;
        RESET = r;
        @(posedge CLK);
        model_update(b, r);
        #1;
    endtask

    task automatic check(input string name, input logic [N_CH-1:0] got,
                         input logic [N_CH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic clean_reset();
        step('0, 1'b1);
        for (int i = 0; i < 3; i++) step('0, 1'b0);
    endtask

    typedef struct {
        logic [N_CH-1:0] btn;
        logic            rst;
        logic [N_CH-1:0] pulse;
        logic [N_CH-1:0] rel;
        logic [N_CH-1:0] lvl;
    } vec_t;

    localparam int NVEC = 30;
    vec_t tbl [NVEC];

    initial begin
        int e;
        logic [N_CH-1:0] hold_val;
        int hold_cnt [N_CH];

        // Both buttons held from edge 1: press on both at 7, repeats on ch0 only.
        for (int i = 0; i < NVEC; i++) begin
            e = i + 1;
            tbl[i].btn   = 2'b11;
            tbl[i].rst   = 1'b0;
            tbl[i].pulse = (e == 7) ? 2'b11 :
                           (e == 17 || e == 22 || e == 27) ? 2'b01 : 2'b00;
            tbl[i].rel   = 2'b00;
            tbl[i].lvl   = (e >= 7) ? 2'b11 : 2'b00;
        end

        Btn   = '0;
        RESET = 1'b1;
        step('0, 1'b1);
        check("reset_pulse", Btn_pulse, 2'b00);
        check("reset_release", Btn_release, 2'b00);
        check("reset_level", Btn_level, 2'b00);
        for (int i = 0; i < 3; i++) step('0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].btn, tbl[i].rst);
            check($sformatf("tbl_pulse[e%0d]", i + 1), Btn_pulse, tbl[i].pulse);
            check($sformatf("tbl_release[e%0d]", i + 1), Btn_release, tbl[i].rel);
            check($sformatf("tbl_level[e%0d]", i + 1), Btn_level, tbl[i].lvl);
        end

        // Release of both: first low-sampling edge is k=0, qualified at k=DC+2.
        for (int k = 0; k < 9; k++) begin
            step(2'b00, 1'b0);
            check($sformatf("release_pulse[k%0d]", k), Btn_release,
                  (k == DC + 2) ? 2'b11 : 2'b00);
            check($sformatf("release_level[k%0d]", k), Btn_level,
                  (k < DC + 2) ? 2'b11 : 2'b00);
        end

        // Press bounce: 3 high / 3 low, five times, never qualifies.
        for (int rep = 0; rep < 5; rep++) begin
            for (int k = 0; k < 6; k++) begin
                step((k < 3) ? 2'b01 : 2'b00, 1'b0);
                check("bounce_pulse", Btn_pulse, 2'b00);
                check("bounce_level", Btn_level, 2'b00);
            end
        end
        for (int k = 0; k < 4; k++) step(2'b00, 1'b0);

        // Release bounce: 2 low cycles inside HELD are absorbed.
        for (int k = 0; k < 10; k++) step(2'b01, 1'b0);
        check("relbounce_pressed", Btn_level, 2'b01);
        for (int k = 0; k < 12; k++) begin
            step((k < 2) ? 2'b00 : 2'b01, 1'b0);
            check("relbounce_release", Btn_release, 2'b00);
            check("relbounce_level", Btn_level, 2'b01);
        end

        // Reset at edge 12 while held; button must requalify, press at 19.
        clean_reset();
        for (int k = 1; k <= 11; k++) step(2'b11, 1'b0);
        check("midreset_held", Btn_level, 2'b11);
        step(2'b11, 1'b1);
        check("midreset_pulse", Btn_pulse, 2'b00);
        check("midreset_release", Btn_release, 2'b00);
        check("midreset_level", Btn_level, 2'b00);
        for (int k = 13; k <= 20; k++) begin
            step(2'b11, 1'b0);
            check($sformatf("repress_pulse[e%0d]", k), Btn_pulse,
                  (k == 19) ? 2'b11 : 2'b00);
            check($sformatf("repress_level[e%0d]", k), Btn_level,
                  (k >= 19) ? 2'b11 : 2'b00);
        end

        // Randomized run against the model, with short glitches and rare resets.
        clean_reset();
        hold_val = '0;
        for (int c = 0; c < N_CH; c++) hold_cnt[c] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hold_cnt[c] == 0) begin
                    hold_val[c] = ~hold_val[c];
                    hold_cnt[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                              : int'($urandom_range(5, 30));
                end
                hold_cnt[c]--;
            end
            step(hold_val, ($urandom_range(0, 299) == 0));
            check("rand_pulse", Btn_pulse, m_pulse);
            check("rand_release", Btn_release, m_rel);
            check("rand_level", Btn_level, m_lvl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
